// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU bus arbiter: FSM states, grant encoding, request bundle.
// No logic, no latency.
// No flow control of its own.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    // One client request as it is loaded into the Avalon registers.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_req_t;

endpackage

// File: rtl/mips_cpu_rr_arbiter2.sv
// Two-way grant selection between fetch and data, round-robin or data-first.
// Grant is combinational; the pointer updates on the edge where advance is high.
// No backpressure; the caller decides when a grant is taken.
module mips_cpu_rr_arbiter2
    import mips_cpu_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   advance,
    input  grant_t served,
    output logic   gnt_vld,
    output grant_t gnt
);

    // Last port served; resetting it to data makes fetch the favoured port.
    grant_t last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= GNT_D;
        end else if (advance) begin
            last <= served;
        end
    end

    always_comb begin
        gnt_vld = req_i | req_d;
        gnt     = GNT_I;
        if (req_i && req_d) begin
            gnt = (FIXED_PRIORITY || (last == GNT_I)) ? GNT_D : GNT_I;
        end else if (req_d) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and load/store, with a stall watchdog.
// Request in IDLE at edge N drives the bus from N+1; ack at N+2 plus one cycle per waitrequest.
// Clients hold req until their ack; waitrequest holds the bus fields until it drops or the watchdog fires.
module mips_cpu_bus_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      state, state_nxt;
    grant_t          owner;
    grant_t          gnt;
    logic            gnt_vld;
    bus_req_t        sel_req;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;
    logic            bus_end;

    mips_cpu_rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY != 0)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (i_req),
        .req_d   (d_req),
        .advance (state == DONE),
        .served  (owner),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    // Fetch is always a full-word read.
    always_comb begin
        if (gnt == GNT_D) begin
            sel_req = '{addr: d_addr, wdata: d_wdata, be: d_be, we: d_we};
        end else begin
            sel_req = '{addr: i_addr, wdata: 32'h0, be: 4'hF, we: 1'b0};
        end
    end

    assign wd_fire = (TIMEOUT_CYCLES != 0) && (state == BUS) && waitrequest
                     && (wd_cnt == WD_LAST);
    assign bus_end = (state == BUS) && (!waitrequest || wd_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = BUS;
            BUS:     if (bus_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            owner      <= GNT_I;
            wd_cnt     <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    address    <= gnt_vld ? sel_req.addr  : '0;
                    writedata  <= gnt_vld ? sel_req.wdata : '0;
                    byteenable <= gnt_vld ? sel_req.be    : '0;
                    read       <= gnt_vld && !sel_req.we;
                    write      <= gnt_vld && sel_req.we;
                    if (gnt_vld) owner <= gnt;
                end
                BUS: begin
                    if (bus_end) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        err   <= wd_fire;
                        i_ack <= (owner == GNT_I);
                        d_ack <= (owner == GNT_D);
                        // A timed-out transfer returns zero rather than whatever is on readdata.
                        if (owner == GNT_I) begin
                            if (wd_fire)   i_rdata <= '0;
                            else if (read) i_rdata <= readdata;
                        end else begin
                            if (wd_fire)   d_rdata <= '0;
                            else if (read) d_rdata <= readdata;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                DONE: wd_cnt <= '0;
                default: wd_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboarded bench: round-robin/timeout instance plus a fixed-priority instance.
module tb_mips_cpu_bus_arbiter;
    import mips_cpu_pkg::*;

    localparam int TO = 8;
    localparam logic [31:0] BOOT_ADDR = 32'hBFC00000;
    localparam logic [31:0] BOOT_WORD = 32'h24020005;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, i_ack, d_req = 0, d_we = 0, d_ack, err;
    logic [31:0] i_addr = 0, i_rdata, d_addr = 0, d_wdata = 0, d_rdata;
    logic [3:0]  d_be = 0, byteenable;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;

    logic        f_i_req = 0, f_i_ack, f_d_req = 0, f_d_we = 0, f_d_ack, f_err;
    logic [31:0] f_i_addr = 0, f_i_rdata, f_d_addr = 0, f_d_wdata = 0, f_d_rdata;
    logic [3:0]  f_d_be = 0, f_byteenable;
    logic [31:0] f_address, f_writedata, f_readdata;
    logic        f_read, f_write, f_waitrequest;

    mips_cpu_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    mips_cpu_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
        .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata), .d_be(f_d_be),
        .d_ack(f_d_ack), .d_rdata(f_d_rdata), .err(f_err),
        .address(f_address), .read(f_read), .write(f_write), .writedata(f_writedata),
        .byteenable(f_byteenable), .waitrequest(f_waitrequest), .readdata(f_readdata)
    );

    // Slave model: stalls the first stall_cfg cycles of every transfer.
    int stall_cfg = 0;
    int busy_n = 0;
    always @(posedge clk) begin
        if (read || write) busy_n <= busy_n + 1;
        else               busy_n <= 0;
    end
    assign waitrequest = (read || write) && (busy_n < stall_cfg);
    assign readdata    = (address == BOOT_ADDR) ? BOOT_WORD : ~address;
    assign f_waitrequest = 1'b0;
    assign f_readdata    = ~f_address;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl_i_rdata = 0;
    logic [31:0] mdl_d_rdata = 0;

    task automatic expect_txn(input bit is_d, input bit we, input logic [31:0] a, input bit tmo);
        exp_t e;
        e.is_d = is_d;
        e.err  = tmo;
        if (tmo)     e.rdata = 32'h0;
        else if (we) e.rdata = mdl_d_rdata;
        else         e.rdata = (a == BOOT_ADDR) ? BOOT_WORD : ~a;
        if (is_d) mdl_d_rdata = e.rdata;
        else      mdl_i_rdata = e.rdata;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (i_ack || d_ack)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 32'(i_ack | d_ack), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_port", 32'(d_ack), 32'(mon_e.is_d));
                check("sb_single_ack", 32'(i_ack & d_ack), 32'h0);
                check("sb_rdata", d_ack ? d_rdata : i_rdata, mon_e.rdata);
                check("sb_err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    // One transaction on the main instance; called just after a rising edge.
    task automatic run_txn(input string tag, input bit is_d, input bit we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int stalls);
        bit tmo = (stalls >= TO);
        int exp_lat = tmo ? TO + 1 : stalls + 2;
        int lat = 0;
        int bus_cyc = 0;
        int bad = 0;
        stall_cfg = stalls;
        expect_txn(is_d, we, a, tmo);
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        end else begin
            i_req = 1; i_addr = a;
        end
        while (lat < 64) begin
            @(negedge clk);
            if (read || write) begin
                bus_cyc++;
                if (address != a || byteenable != (is_d ? be : 4'hF) || read == we
                    || write != we || (we && writedata != wd))
                    bad++;
            end
            if (is_d ? d_ack : i_ack) break;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_bus_cycles"}, 32'(bus_cyc), 32'(exp_lat - 1));
        check({tag, "_fields"}, 32'(bad), 32'h0);
        @(posedge clk); #1;
        i_req = 0; d_req = 0; d_we = 0;
    endtask

    // Both ports held high on the main instance; round-robin must alternate from fetch.
    task automatic run_both(input string tag, input int n);
        int cnt = 0;
        stall_cfg = 0;
        i_addr = 32'h00400000; d_addr = 32'h00003000; d_we = 0; d_be = 4'hF;
        for (int k = 0; k < n; k++) expect_txn(k[0], 1'b0, k[0] ? d_addr : i_addr, 1'b0);
        i_req = 1; d_req = 1;
        for (int c = 0; c < 20 * n && cnt < n; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) cnt++;
        end
        check({tag, "_acks"}, 32'(cnt), 32'(n));
        @(posedge clk); #1;
        i_req = 0; d_req = 0;
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", 32'(read), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_acks", 32'({i_ack, d_ack, err}), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        run_txn("fetch", 1'b0, 1'b0, BOOT_ADDR, 32'h0, 4'hF, 0);
        run_txn("dread", 1'b1, 1'b0, 32'h00001008, 32'h0, 4'hF, 1);
        run_txn("dwrite", 1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 3);
        run_both("rr", 4);

        // Fixed priority: data wins every arbitration while both are held.
        cnt = 0;
        f_i_addr = 32'h00400010; f_d_addr = 32'h00005000; f_d_be = 4'hF;
        f_i_req = 1; f_d_req = 1;
        for (int c = 0; c < 80 && cnt < 4; c++) begin
            @(negedge clk);
            if (f_i_ack || f_d_ack) begin
                cnt++;
                check("fp_grant_d", 32'(f_d_ack), 32'h1);
                check("fp_rdata", f_d_rdata, ~32'h00005000);
            end
        end
        check("fp_acks", 32'(cnt), 32'h4);
        @(posedge clk); #1;
        f_i_req = 0; f_d_req = 0;

        run_txn("timeout", 1'b1, 1'b0, 32'h00002000, 32'h0, 4'hF, 1000);

        // Serve fetch last so that, without reset, data would be favoured next.
        run_txn("pre_rst_fetch", 1'b0, 1'b0, 32'h00400020, 32'h0, 4'hF, 0);
        stall_cfg = 1000;
        d_req = 1; d_we = 0; d_addr = 32'h00007000; d_be = 4'hF;
        repeat (2) @(negedge clk);
        check("mid_rst_read_before", 32'(read), 32'h1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_read", 32'(read), 32'h0);
        check("mid_rst_address", address, 32'h0);
        check("mid_rst_acks", 32'({i_ack, d_ack, err}), 32'h0);
        d_req = 0; stall_cfg = 0;
        mdl_i_rdata = 0; mdl_d_rdata = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        run_both("post_rst", 2);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
